// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter: event codes, CP0
// register addresses, status bit positions and flag-vector layout.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TR   = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  // Bit positions inside the packed per-instruction flag vector
  localparam int FLG_ADEL_IF = 8;
  localparam int FLG_RI      = 7;
  localparam int FLG_SYSCALL = 6;
  localparam int FLG_BREAK   = 5;
  localparam int FLG_OV      = 4;
  localparam int FLG_TRAP    = 3;
  localparam int FLG_ADEL_LD = 2;
  localparam int FLG_ADES    = 1;
  localparam int FLG_ERET    = 0;

  localparam logic [1:0] BAD_NONE = 2'd0;
  localparam logic [1:0] BAD_PC   = 2'd1;
  localparam logic [1:0] BAD_DATA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_MASK  = 2'd2
  } state_t;

endpackage

// File: rtl/except_ctrl_prio.sv
// Fixed-priority encoder: picks one event code from the interrupt request and
// the instruction's exception flags, plus which address is the faulting one.
module except_ctrl_prio
  import except_ctrl_pkg::*;
(
  input  logic        int_req,
  input  logic [8:0]  flags,
  output logic [31:0] code,
  output logic [1:0]  bad_sel
);

  always_comb begin
    code    = EXC_NONE;
    bad_sel = BAD_NONE;
    if (int_req) begin
      code = EXC_INT;
    end else if (flags[FLG_ADEL_IF]) begin
      code    = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (flags[FLG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLG_SYSCALL]) begin
      code = EXC_SYS;
    end else if (flags[FLG_BREAK]) begin
      code = EXC_BP;
    end else if (flags[FLG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLG_TRAP]) begin
      code = EXC_TR;
    end else if (flags[FLG_ADEL_LD]) begin
      code    = EXC_ADEL;
      bad_sel = BAD_DATA;
    end else if (flags[FLG_ADES]) begin
      code    = EXC_ADES;
      bad_sel = BAD_DATA;
    end else if (flags[FLG_ERET]) begin
      code = EXC_ERET;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception/interrupt arbiter: same-cycle event report to CP0,
// registered flush/redirect one cycle later, then a short wrong-path mask window.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          MASK_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] data_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_syscall_i,
  input  logic        exc_break_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  state_t      state;
  logic [3:0]  mask_cnt;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_req, accept;
  logic [31:0] prio_code;
  logic [1:0]  bad_sel;
  logic [8:0]  flags;
  logic        unused_bits;

  // An mtc0 retiring in WB this cycle must be visible to the arbiter now
  assign status_eff = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign epc_eff    = (cp0_we_i && cp0_waddr_i == CP0_EPC)    ? cp0_wdata_i : cp0_epc_i;
  assign cause_eff  = {cp0_cause_i[31:10],
                       (cp0_we_i && cp0_waddr_i == CP0_CAUSE) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8],
                       cp0_cause_i[7:0]};
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  assign int_req = (|(status_eff[15:8] & cause_eff[15:8])) &
                   status_eff[STATUS_IE] & ~status_eff[STATUS_EXL];

  assign flags = {exc_adel_if_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_ov_i,
                  exc_trap_i, exc_adel_ld_i, exc_ades_i, exc_eret_i};

  except_ctrl_prio u_prio (
    .int_req (int_req),
    .flags   (flags),
    .code    (prio_code),
    .bad_sel (bad_sel)
  );

  assign accept = !rst && (state == S_IDLE) && valid_i && !stall_i;

  always_comb begin
    excepttype_o        = accept ? prio_code : EXC_NONE;
    current_inst_addr_o = rst ? 32'h0 : pc_i;
    is_in_delayslot_o   = rst ? 1'b0 : in_delayslot_i;
    bad_addr_o          = 32'h0;
    if (accept && bad_sel == BAD_PC)
      bad_addr_o = pc_i;
    else if (accept && bad_sel == BAD_DATA)
      bad_addr_o = data_addr_i;
  end

  // Commit edge: event recorded in cp0, flush and redirect registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mask_cnt <= 4'd0;
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (excepttype_o != EXC_NONE) begin
            state    <= S_FLUSH;
            flush_o  <= 1'b1;
            busy_o   <= 1'b1;
            new_pc_o <= (excepttype_o == EXC_ERET) ? epc_eff : EXC_VECTOR;
          end
        end
        S_FLUSH: begin
          state    <= S_MASK;
          flush_o  <= 1'b0;
          mask_cnt <= 4'(MASK_CYCLES);
        end
        S_MASK: begin
          mask_cnt <= mask_cnt - 4'd1;
          if (mask_cnt <= 4'd1) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            mask_cnt <= 4'd0;
          end
        end
        default: begin
          state   <= S_IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: hand-computed codes, flush/redirect timing,
// mask window, stall handling and reset recovery.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, in_delayslot_i;
  logic [31:0] pc_i, data_addr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_ov_i;
  logic        exc_trap_i, exc_adel_ld_i, exc_ades_i, exc_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  except_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .data_addr_i(data_addr_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_syscall_i(exc_syscall_i),
    .exc_break_i(exc_break_i), .exc_ov_i(exc_ov_i), .exc_trap_i(exc_trap_i),
    .exc_adel_ld_i(exc_adel_ld_i), .exc_ades_i(exc_ades_i), .exc_eret_i(exc_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = 0; stall_i = 0; in_delayslot_i = 0;
    pc_i = 32'h0000_0100; data_addr_i = 32'h0;
    exc_adel_if_i = 0; exc_ri_i = 0; exc_syscall_i = 0; exc_break_i = 0;
    exc_ov_i = 0; exc_trap_i = 0; exc_adel_ld_i = 0; exc_ades_i = 0; exc_eret_i = 0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    cp0_we_i = 0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'h0;
  endtask

  // Clears inputs and walks through the rest of the FLUSH + 3-cycle MASK window
  task automatic drain(input string tag);
    clear_inputs();
    repeat (4) tick();
    chk({tag, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    valid_i = 1; exc_syscall_i = 1;
    #1;
    chk("rst_excepttype", excepttype_o, 32'h0);
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_new_pc", new_pc_o, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    clear_inputs();
    tick();
    rst = 0;
    tick();

    // Combinational-only checks in IDLE (no edge consumed with an event present)
    valid_i = 1; exc_syscall_i = 1; valid_i = 0;
    #1 chk("bubble_masked", excepttype_o, 32'h0);
    valid_i = 1; cp0_status_i = 32'h0000_FF03; cp0_cause_i = 32'h0000_0400;
    #1 chk("exl_blocks_int", excepttype_o, 32'h8);
    cp0_status_i = 32'h0; cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_FF01;
    #1 chk("status_bypass_int", excepttype_o, 32'h1);
    clear_inputs();
    valid_i = 1; cp0_status_i = 32'h0000_0101; cp0_we_i = 1; cp0_waddr_i = 5'd13;
    cp0_wdata_i = 32'h0000_0100; exc_break_i = 1;
    #1 chk("cause_bypass_int", excepttype_o, 32'h1);
    clear_inputs();
    valid_i = 1; pc_i = 32'h0000_2001; exc_adel_if_i = 1; exc_ri_i = 1; in_delayslot_i = 1;
    #1 chk("adel_if_code", excepttype_o, 32'h4);
    chk("adel_if_bad", bad_addr_o, 32'h0000_2001);
    chk("pc_passthru", current_inst_addr_o, 32'h0000_2001);
    chk("ds_passthru", {31'h0, is_in_delayslot_o}, 32'h1);
    clear_inputs();
    valid_i = 1; exc_adel_ld_i = 1; exc_eret_i = 1; data_addr_i = 32'h0000_0042;
    #1 chk("adel_ld_code", excepttype_o, 32'h4);
    chk("adel_ld_bad", bad_addr_o, 32'h0000_0042);
    clear_inputs();
    #1;

    // Interrupt
    valid_i = 1; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
    #1 chk("int_code", excepttype_o, 32'h1);
    chk("int_bad", bad_addr_o, 32'h0);
    chk("int_flush_early", {31'h0, flush_o}, 32'h0);
    tick();
    chk("int_flush", {31'h0, flush_o}, 32'h1);
    chk("int_new_pc", new_pc_o, 32'hBFC0_0380);
    chk("int_flush_code0", excepttype_o, 32'h0);
    chk("int_busy_f", {31'h0, busy_o}, 32'h1);
    clear_inputs();
    tick();
    chk("int_flush_fall", {31'h0, flush_o}, 32'h0);
    chk("int_busy_m1", {31'h0, busy_o}, 32'h1);
    tick();
    chk("int_busy_m2", {31'h0, busy_o}, 32'h1);
    tick();
    chk("int_busy_m3", {31'h0, busy_o}, 32'h1);
    tick();
    chk("int_busy_idle", {31'h0, busy_o}, 32'h0);

    // Simultaneous Ov + AdES
    valid_i = 1; exc_ov_i = 1; exc_ades_i = 1; data_addr_i = 32'h8000_0003;
    #1 chk("ov_wins_code", excepttype_o, 32'hc);
    chk("ov_wins_bad", bad_addr_o, 32'h0);
    exc_ov_i = 0;
    #1 chk("ades_code", excepttype_o, 32'h5);
    chk("ades_bad", bad_addr_o, 32'h8000_0003);
    tick();
    chk("ades_flush", {31'h0, flush_o}, 32'h1);
    chk("ades_new_pc", new_pc_o, 32'hBFC0_0380);
    drain("ades");

    // ERET with same-cycle EPC write
    valid_i = 1; exc_eret_i = 1; cp0_epc_i = 32'h0000_1000;
    cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'hBFC0_0100;
    #1 chk("eret_code", excepttype_o, 32'he);
    tick();
    chk("eret_flush", {31'h0, flush_o}, 32'h1);
    chk("eret_new_pc", new_pc_o, 32'hBFC0_0100);
    drain("eret");

    // Stall then unstall
    valid_i = 1; exc_syscall_i = 1; stall_i = 1;
    #1 chk("stall_c1", excepttype_o, 32'h0);
    tick();
    chk("stall_c2", excepttype_o, 32'h0);
    chk("stall_noflush", {31'h0, flush_o}, 32'h0);
    tick();
    chk("stall_c3", excepttype_o, 32'h0);
    tick();
    stall_i = 0;
    #1 chk("stall_c4", excepttype_o, 32'h8);
    tick();
    chk("stall_flush", {31'h0, flush_o}, 32'h1);
    chk("stall_once", excepttype_o, 32'h0);
    drain("stall");

    // Mask window
    valid_i = 1; exc_break_i = 1;
    #1 chk("mask_first", excepttype_o, 32'h9);
    tick();
    chk("mask_flush", {31'h0, flush_o}, 32'h1);
    tick();
    chk("mask_m1", excepttype_o, 32'h0);
    tick();
    chk("mask_m2", excepttype_o, 32'h0);
    tick();
    chk("mask_m3", excepttype_o, 32'h0);
    chk("mask_m3_noflush", {31'h0, flush_o}, 32'h0);
    tick();
    chk("mask_idle_code", excepttype_o, 32'h9);
    chk("mask_idle_busy", {31'h0, busy_o}, 32'h0);
    tick();
    chk("mask_reflush", {31'h0, flush_o}, 32'h1);
    drain("mask");

    // Reset mid-MASK
    valid_i = 1; exc_ri_i = 1;
    #1 chk("rstm_code", excepttype_o, 32'ha);
    tick();
    clear_inputs();
    tick();
    chk("rstm_in_mask", {31'h0, busy_o}, 32'h1);
    rst = 1; valid_i = 1; exc_trap_i = 1;
    #1 chk("rstm_forced0", excepttype_o, 32'h0);
    tick();
    rst = 0;
    #1;
    chk("rstm_busy", {31'h0, busy_o}, 32'h0);
    chk("rstm_flush", {31'h0, flush_o}, 32'h0);
    chk("rstm_new_pc", new_pc_o, 32'h0);
    chk("rstm_accept", excepttype_o, 32'hd);
    tick();
    chk("rstm_reflush", {31'h0, flush_o}, 32'h1);
    chk("rstm_vec", new_pc_o, 32'hBFC0_0380);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- MEM-stage exception/interrupt arbiter. It is the producer side of the CP0 exception interface.
- Each cycle it collects per-instruction exception flags and the pending hardware interrupts, and picks at most one event.
- It drives excepttype/current_inst_addr/is_in_delayslot/bad_addr into cp0 for same-edge commit.
- One cycle later it issues a registered pipeline flush and redirect PC, then masks wrong-path events for a short drain window.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET.
- MASK_CYCLES, 3, number of cycles after the flush cycle during which new events are ignored (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  MEM-stage instruction is real (not a bubble)
- stall_i  in  1  MEM stage is stalled this cycle; no event may be committed
- pc_i  in  32  MEM-stage instruction address
- in_delayslot_i  in  1  MEM instruction sits in a branch delay slot
- data_addr_i  in  32  load/store effective address
- exc_adel_if_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_ov_i, exc_trap_i, exc_adel_ld_i, exc_ades_i, exc_eret_i  in  1 each  per-instruction flags
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current cp0 register values
- cp0_we_i  in  1  WB-stage mtc0 write enable (bypass)
- cp0_waddr_i  in  5  mtc0 target register
- cp0_wdata_i  in  32  mtc0 data
- excepttype_o  out  32  event code to cp0; 0 means no event
- current_inst_addr_o  out  32  pc_i passthrough to cp0
- is_in_delayslot_o  out  1  in_delayslot_i passthrough to cp0
- bad_addr_o  out  32  faulting address to cp0
- flush_o  out  1  registered, one-cycle pipeline flush pulse
- new_pc_o  out  32  registered redirect target, valid while flush_o=1
- busy_o  out  1  high during FLUSH or MASK

Behaviour:
- Bypass: effective status is cp0_wdata_i when cp0_we_i and waddr==12; otherwise cp0_status_i.
- Bypass: effective epc is cp0_wdata_i when cp0_we_i and waddr==14; otherwise cp0_epc_i.
- Bypass: effective cause[9:8] comes from cp0_wdata_i[9:8] when cp0_we_i and waddr==13.
- Interrupt request: int_req = |(status[15:8] & cause[15:8]) & status[0] & ~status[1].
- Arbitration is combinational and applies only in IDLE with valid_i=1 and stall_i=0. The highest-priority event wins:
  - interrupt: code 32'h1
  - AdEL fetch: 32'h4, bad_addr = pc_i
  - RI: 32'ha
  - syscall: 32'h8
  - break: 32'h9
  - Ov: 32'hc
  - trap: 32'hd
  - AdEL load: 32'h4, bad_addr = data_addr_i
  - AdES: 32'h5, bad_addr = data_addr_i
  - ERET: 32'he
- If no event wins, excepttype_o=0.
- bad_addr_o = 0 for every code other than 4 and 5.
- current_inst_addr_o and is_in_delayslot_o pass through pc_i and in_delayslot_i in all states.
- Zero-forcing: excepttype_o=0 in FLUSH or MASK, when stall_i=1, when valid_i=0, and during rst.
- State machine (IDLE, FLUSH, MASK) with a 4-bit down-counter:
  - IDLE -> FLUSH on any nonzero excepttype_o. The same edge loads flush_o<=1, and new_pc_o <= effective epc for ERET or EXC_VECTOR otherwise.
  - FLUSH lasts exactly 1 cycle; flush_o deasserts on leaving it. FLUSH -> MASK, loading counter = MASK_CYCLES.
  - MASK decrements the counter each cycle and goes to IDLE when the counter reaches 1. busy_o=1 in FLUSH and MASK.
  - An event presented on the first IDLE cycle after MASK is accepted.
- Latency: excepttype_o is same cycle as the flags (0 cycles). flush_o and new_pc_o rise 1 cycle later.
- Simultaneous events: only the winner is reported; losers are discarded, since the flush kills the instruction.
- Stall then unstall: the event is reported on the first unstalled cycle only, never twice.
- Reset:
  - Effective on the next edge, including mid-FLUSH or mid-MASK. State goes to IDLE, counter to 0.
  - flush_o=0, new_pc_o=0, busy_o=0; combinational outputs are forced to 0 while rst=1.

Decomposition:
- Shared package (defines.vh):
  - exception code constants
  - CP0 register addresses 12/13/14
  - status bit indices IE=0, EXL=1
  - EXC_VECTOR default
- One natural sub-module: except_prio, a pure combinational priority encoder (flags, int_req) -> (code, bad_addr_sel).
- The FSM, bypass and registers stay in except_ctrl.

Test Plan:
- Interrupt: status=32'h0000FF01, cause[10]=1, valid_i=1 -> excepttype_o=32'h1 same cycle. Next cycle flush_o=1, new_pc_o=32'hBFC00380. busy_o stays high for 1+3 cycles.
- Simultaneous: exc_ov_i=1 with exc_ades_i=1, data_addr_i=32'h80000003 -> code 32'hc, bad_addr_o=0. Same with ov=0 -> code 32'h5, bad_addr_o=32'h80000003.
- ERET bypass: cp0_epc_i=32'h1000, same-cycle mtc0 epc=32'hBFC00100 -> code 32'he. Next cycle new_pc_o=32'hBFC00100.
- Stall: exc_syscall_i=1 with stall_i=1 for 3 cycles, then 0 -> code 32'h8 appears only on the 4th cycle, exactly once.
- Mask window: a second exc_break_i on each of the 3 MASK cycles -> excepttype_o=0. exc_break_i held to the first IDLE cycle -> 32'h9.
- Reset mid-MASK: rst=1 for 1 cycle -> state IDLE, busy_o=0, flush_o=0. The next flagged instruction is accepted immediately.
